axis_read_sched: RTL and testbench

Read-side scheduler sitting in front of the AXI read data channel handler. Accepts a stream request (byte address, length in stream words), hands the stream length to the read data block's config port, then splits the transfer into AXI read-address bursts while bounding the number of bursts in flight. One request is processed at a time; ordering of AR bursts matches request order.

---
 rtl/axis_read_sched.sv | 166 ++++++++++++++++
 tb/tb_axis_read_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_read_sched.sv
// axis_read_sched: read-side scheduler in front of the AXI read data handler.
// Accepts one stream request at a time. It passes the stream length to the
// read data block, then splits the transfer into AR bursts while keeping the
// number of bursts in flight bounded.
// Optional build macro: AXIS_READ_SCHED_4K_EN. When it is defined, bursts are
// also clipped so that none of them crosses a 4 KB boundary.
module axis_read_sched #(
  parameter int CFG_DWIDTH      = 32,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int WIDTH_RATIO     = 2,
  parameter int BURST_MAX       = 16,
  parameter int OUTSTANDING_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CFG_DWIDTH-1:0]     cfg_address,
  input  logic [CFG_DWIDTH-1:0]     cfg_length,
  input  logic                      cfg_val,
  output logic                      cfg_rdy,
  output logic [CFG_DWIDTH-1:0]     data_cfg_length,
  output logic                      data_cfg_val,
  input  logic                      data_cfg_rdy,
  output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
  output logic [7:0]                axi_arlen,
  output logic                      axi_arvalid,
  input  logic                      axi_arready,
  input  logic                      axi_rlast,
  input  logic                      axi_rvalid,
  input  logic                      axi_rready
);

  localparam int BYTES       = AXI_DATA_WIDTH / 8;
  localparam int BYTE_SHIFT  = $clog2(BYTES);
  localparam int RATIO_SHIFT = $clog2(WIDTH_RATIO);
  localparam int REM_W       = CFG_DWIDTH + 1;
  localparam int CNT_W       = $clog2(OUTSTANDING_MAX + 1);

  localparam logic [REM_W-1:0] RATIO_ROUND = REM_W'(WIDTH_RATIO - 1);
  localparam logic [REM_W-1:0] BURST_LIM   = REM_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] OUT_LIM     = CNT_W'(OUTSTANDING_MAX);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    DCFG  = 3'b010,
    ISSUE = 3'b100
  } state_t;

  state_t                    state;
  logic [REM_W-1:0]          beats_rem;
  logic [CNT_W-1:0]          outstanding;
  logic [CNT_W-1:0]          outstanding_next;
  logic                      ar_hs;
  logic                      rlast_hs;
  logic                      cfg_hs;
  logic [8:0]                burst_cur;
  logic [8:0]                burst_load;
  logic [8:0]                burst_next;
  logic [AXI_ADDR_WIDTH-1:0] addr_req;
  logic [AXI_ADDR_WIDTH-1:0] addr_next;
  logic [REM_W-1:0]          beats_req;
  logic [REM_W-1:0]          rem_next;

`ifdef AXIS_READ_SCHED_4K_EN
  // Burst size limited by remaining beats, BURST_MAX and room left in the 4 KB page.
  function automatic logic [8:0] burst_of(input logic [11:0] page_off,
                                          input logic [REM_W-1:0] rem);
    logic [8:0]  b;
    logic [12:0] room;
    b    = (rem > BURST_LIM) ? 9'(BURST_MAX) : rem[8:0];
    room = (13'd4096 - {1'b0, page_off}) >> BYTE_SHIFT;
    if (room < {4'd0, b}) b = room[8:0];
    return b;
  endfunction
`else
  // Burst size limited by remaining beats and BURST_MAX.
  function automatic logic [8:0] burst_of(input logic [REM_W-1:0] rem);
    return (rem > BURST_LIM) ? 9'(BURST_MAX) : rem[8:0];
  endfunction
`endif

  // NOTE: cfg_rdy is a pure decode of the one-hot state register, so no extra flop is needed.
  assign cfg_rdy = (state == IDLE);

  // Handshake decode, the next burst after an AR handshake, and the outstanding counter update.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path infers a latch.
    outstanding_next = outstanding;
    ar_hs            = axi_arvalid && axi_arready;
    rlast_hs         = axi_rvalid && axi_rready && axi_rlast;
    cfg_hs           = cfg_val && cfg_rdy;
    burst_cur        = {1'b0, axi_arlen} + 9'd1;
    addr_next        = axi_araddr + (AXI_ADDR_WIDTH'(burst_cur) << BYTE_SHIFT);
    rem_next         = beats_rem - REM_W'(burst_cur);
    beats_req        = ({1'b0, cfg_length} + RATIO_ROUND) >> RATIO_SHIFT;
    addr_req         = AXI_ADDR_WIDTH'(cfg_address);
    // An rlast that arrives while the counter is 0 has no burst to retire and is dropped.
    unique case ({ar_hs, rlast_hs && (outstanding != '0)})
      2'b10:   outstanding_next = outstanding + CNT_W'(1);
      2'b01:   outstanding_next = outstanding - CNT_W'(1);
      default: outstanding_next = outstanding;
    endcase
`ifdef AXIS_READ_SCHED_4K_EN
    burst_load = burst_of(addr_req[11:0], beats_req);
    burst_next = burst_of(addr_next[11:0], rem_next);
`else
    burst_load = burst_of(beats_req);
    burst_next = burst_of(rem_next);
`endif
  end

  // Request FSM with registered data_cfg and AR channel outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      beats_rem       <= '0;
      outstanding     <= '0;
      data_cfg_length <= '0;
      data_cfg_val    <= 1'b0;
      axi_araddr      <= '0;
      axi_arlen       <= '0;
      axi_arvalid     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      outstanding <= outstanding_next;
      unique case (state)
        IDLE: begin
          // A zero-length request is consumed without producing any work.
          if (cfg_hs && (cfg_length != '0)) begin
            axi_araddr      <= addr_req;
            axi_arlen       <= 8'(burst_load - 9'd1);
            beats_rem       <= beats_req;
            data_cfg_length <= cfg_length;
            data_cfg_val    <= 1'b1;
            state           <= DCFG;
          end
        end
        DCFG: begin
          if (data_cfg_rdy) begin
            data_cfg_val <= 1'b0;
            axi_arvalid  <= (outstanding_next < OUT_LIM);
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (ar_hs) begin
            axi_araddr <= addr_next;
            beats_rem  <= rem_next;
            if (rem_next == '0) begin
              axi_arvalid <= 1'b0;
              state       <= IDLE;
            end else begin
              axi_arlen   <= 8'(burst_next - 9'd1);
              axi_arvalid <= (outstanding_next < OUT_LIM);
            end
          end else if (!axi_arvalid) begin
            // An asserted arvalid is never withdrawn. It is only raised when there is room for another burst.
            axi_arvalid <= (outstanding_next < OUT_LIM);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_read_sched.sv
// Testbench for axis_read_sched. A reference model predicts the AR burst list
// of every request using plain arithmetic. It also tracks the handshake-level
// expectations for cfg_rdy, data_cfg_val and arvalid on every cycle.
`timescale 1ns/1ps
module tb_axis_read_sched;

  localparam int BYTES = 8;
  localparam int WR    = 2;
  localparam int BMAX  = 16;
  localparam int OMAX  = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_address;
  logic [31:0] cfg_length;
  logic        cfg_val;
  logic        cfg_rdy;
  logic [31:0] data_cfg_length;
  logic        data_cfg_val;
  logic        data_cfg_rdy;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic        axi_arvalid;
  logic        axi_arready;
  logic        axi_rlast;
  logic        axi_rvalid;
  logic        axi_rready;

  always #5 clk = ~clk;

  axis_read_sched dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_address     (cfg_address),
    .cfg_length      (cfg_length),
    .cfg_val         (cfg_val),
    .cfg_rdy         (cfg_rdy),
    .data_cfg_length (data_cfg_length),
    .data_cfg_val    (data_cfg_val),
    .data_cfg_rdy    (data_cfg_rdy),
    .axi_araddr      (axi_araddr),
    .axi_arlen       (axi_arlen),
    .axi_arvalid     (axi_arvalid),
    .axi_arready     (axi_arready),
    .axi_rlast       (axi_rlast),
    .axi_rvalid      (axi_rvalid),
    .axi_rready      (axi_rready)
  );

  int          n_vec = 0;
  int          n_err = 0;
  ar_t         exp_q[$];
  int          m_out;
  bit          m_busy;
  bit          m_dpend;
  logic [31:0] m_dlen;
  bit          m_arv_exp;
  int          ar_cnt;
  bit          last_cfg_hs;
  bit          rand_en;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected burst list: ceil(len/WR) beats, at most BMAX per burst (and within one 4 KB page when enabled).
  function automatic void plan(input logic [31:0] addr, input logic [31:0] len);
    longint beats;
    longint a;
    longint b;
    beats = (longint'(len) + WR - 1) / WR;
    a     = longint'(addr);
    while (beats > 0) begin
      b = (beats < BMAX) ? beats : longint'(BMAX);
`ifdef AXIS_READ_SCHED_4K_EN
      if ((4096 - (a % 4096)) / BYTES < b) b = (4096 - (a % 4096)) / BYTES;
`endif
      exp_q.push_back('{addr: 32'(a), len: 8'(b - 1)});
      a     = a + b * BYTES;
      beats = beats - b;
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_out     = 0;
    m_busy    = 0;
    m_dpend   = 0;
    m_dlen    = '0;
    m_arv_exp = 0;
  endfunction

  // One clock cycle. Outputs are compared at the negedge, then the model is advanced by the handshakes the coming posedge will take.
  task automatic tick();
    bit ar_hs;
    bit rl_hs;
    bit cfg_hs;
    bit dc_hs;
    check("cfg_rdy", 64'(cfg_rdy), 64'(!m_busy));
    check("data_cfg_val", 64'(data_cfg_val), 64'(m_dpend));
    if (m_dpend) check("data_cfg_length", 64'(data_cfg_length), 64'(m_dlen));
    check("arvalid", 64'(axi_arvalid), 64'(m_arv_exp));
    if (m_arv_exp) begin
      if (exp_q.size() > 0) begin
        check("araddr", 64'(axi_araddr), 64'(exp_q[0].addr));
        check("arlen", 64'(axi_arlen), 64'(exp_q[0].len));
      end else begin
        check("ar_queue_empty", 64'(exp_q.size()), 64'(1));
      end
    end
    ar_hs  = axi_arvalid && axi_arready;
    rl_hs  = axi_rvalid && axi_rready && axi_rlast;
    cfg_hs = cfg_val && cfg_rdy;
    dc_hs  = data_cfg_val && data_cfg_rdy;
    last_cfg_hs = cfg_hs;
    if (ar_hs) begin
      ar_cnt++;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (exp_q.size() == 0) m_busy = 0;
    end
    m_out = m_out + (ar_hs ? 1 : 0) - ((rl_hs && m_out > 0) ? 1 : 0);
    if (dc_hs) m_dpend = 0;
    if (cfg_hs && cfg_length != 0) begin
      plan(cfg_address, cfg_length);
      m_busy  = 1;
      m_dpend = 1;
      m_dlen  = cfg_length;
    end
    m_arv_exp = (axi_arvalid && !axi_arready) || (m_busy && !m_dpend && m_out < OMAX);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycle();
    if (rand_en) begin
      axi_arready  = ($urandom_range(0, 99) < 70);
      data_cfg_rdy = ($urandom_range(0, 99) < 60);
      axi_rvalid   = ($urandom_range(0, 99) < 60);
      axi_rready   = ($urandom_range(0, 99) < 70);
      axi_rlast    = (m_out > 0) && ($urandom_range(0, 99) < 40);
    end
    tick();
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] l);
    int n;
    n = 0;
    cfg_address = a;
    cfg_length  = l;
    cfg_val     = 1'b1;
    last_cfg_hs = 0;
    while (!last_cfg_hs && n < 200) begin
      cycle();
      n++;
    end
    cfg_val = 1'b0;
    check("cfg_accept", 64'(last_cfg_hs), 64'(1));
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (m_busy && n < budget) begin
      cycle();
      n++;
    end
    check("idle_timeout", 64'(m_busy), 64'(0));
  endtask

  // Return rlasts until the model has no bursts in flight. Only called while idle.
  task automatic drain();
    int n;
    n = 0;
    while (m_out > 0 && n < 50) begin
      axi_rvalid = 1'b1;
      axi_rready = 1'b1;
      axi_rlast  = 1'b1;
      tick();
      n++;
    end
    axi_rlast = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    int          n;
    logic [31:0] ra;
    logic [31:0] rl;

    rst = 1'b1; cfg_val = 1'b0; cfg_address = '0; cfg_length = '0;
    data_cfg_rdy = 1'b0; axi_arready = 1'b0; axi_rlast = 1'b0;
    axi_rvalid = 1'b0; axi_rready = 1'b0; rand_en = 0; ar_cnt = 0;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_cfg_rdy", 64'(cfg_rdy), 64'(1));
    check("rst_data_cfg_val", 64'(data_cfg_val), 64'(0));
    check("rst_arvalid", 64'(axi_arvalid), 64'(0));
    check("rst_araddr", 64'(axi_araddr), 64'(0));
    check("rst_arlen", 64'(axi_arlen), 64'(0));
    rst = 1'b0;
    tick();

    // 0x1000 / 64 words -> two 16-beat bursts
    axi_arready = 1'b1; data_cfg_rdy = 1'b1;
    base = ar_cnt;
    send(32'h1000, 32'd64);
    check("t1_dcfg_val", 64'(data_cfg_val), 64'(1));
    check("t1_dcfg_len", 64'(data_cfg_length), 64'(64));
    wait_idle(100);
    check("t1_ar_count", 64'(ar_cnt - base), 64'(2));
    tick();
    check("t1_cfg_rdy_back", 64'(cfg_rdy), 64'(1));
    drain();

    // 5 words -> 3 beats in one burst. A zero-length request is then swallowed.
    base = ar_cnt;
    send(32'h0200, 32'd5);
    wait_idle(100);
    check("t2_ar_count", 64'(ar_cnt - base), 64'(1));
    drain();
    base = ar_cnt;
    send(32'h0300, 32'd0);
    repeat (4) tick();
    check("t2_zero_cfg_rdy", 64'(cfg_rdy), 64'(1));
    check("t2_zero_dcfg", 64'(data_cfg_val), 64'(0));
    check("t2_zero_ar_count", 64'(ar_cnt - base), 64'(0));

    // Stray rlasts at counter 0, then outstanding limit with 256 words (8 bursts)
    axi_rvalid = 1'b1; axi_rready = 1'b1; axi_rlast = 1'b1;
    repeat (2) tick();
    axi_rlast = 1'b0;
    base = ar_cnt;
    send(32'h0000, 32'd256);
    repeat (30) tick();
    check("t3_limit_count", 64'(ar_cnt - base), 64'(4));
    check("t3_limit_arvalid", 64'(axi_arvalid), 64'(0));
    axi_arready = 1'b0; axi_rlast = 1'b1;
    tick();
    axi_rlast = 1'b0;
    check("t3_rlast_reopens", 64'(axi_arvalid), 64'(1));
    axi_arready = 1'b1; axi_rlast = 1'b1;
    tick();
    axi_rlast = 1'b0;
    check("t3_simul_keeps_3", 64'(axi_arvalid), 64'(1));
    tick();
    check("t3_full_again", 64'(axi_arvalid), 64'(0));
    rand_en = 1;
    wait_idle(2000);
    rand_en = 0;
    check("t3_total_count", 64'(ar_cnt - base), 64'(8));
    drain();

    // data_cfg_rdy low 5 cycles, then arready low 10 cycles
    axi_arready = 1'b0; data_cfg_rdy = 1'b0;
    send(32'h0400, 32'd16);
    repeat (5) tick();
    check("t4_no_ar_before_dcfg", 64'(axi_arvalid), 64'(0));
    data_cfg_rdy = 1'b1;
    repeat (10) tick();
    check("t4_hold_arvalid", 64'(axi_arvalid), 64'(1));
    check("t4_hold_araddr", 64'(axi_araddr), 64'(32'h0400));
    check("t4_hold_arlen", 64'(axi_arlen), 64'(7));
    axi_arready = 1'b1;
    wait_idle(50);
    drain();

    // 0x0FC0 / 64 words: 4 KB split when enabled
    base = ar_cnt;
    send(32'h0FC0, 32'd64);
    wait_idle(100);
`ifdef AXIS_READ_SCHED_4K_EN
    check("t5_ar_count", 64'(ar_cnt - base), 64'(3));
`else
    check("t5_ar_count", 64'(ar_cnt - base), 64'(2));
`endif
    drain();

    // Asynchronous reset during ISSUE after the first AR
    base = ar_cnt;
    send(32'h3000, 32'd256);
    n = 0;
    while (ar_cnt == base && n < 20) begin
      tick();
      n++;
    end
    check("t6_first_ar_seen", 64'(ar_cnt - base), 64'(1));
    rst = 1'b1;
    #1;
    check("t6_rst_arvalid", 64'(axi_arvalid), 64'(0));
    check("t6_rst_araddr", 64'(axi_araddr), 64'(0));
    check("t6_rst_arlen", 64'(axi_arlen), 64'(0));
    check("t6_rst_cfg_rdy", 64'(cfg_rdy), 64'(1));
    check("t6_rst_dcfg_val", 64'(data_cfg_val), 64'(0));
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    base = ar_cnt;
    send(32'h2000, 32'd8);
    wait_idle(50);
    check("t6_after_rst_count", 64'(ar_cnt - base), 64'(1));
    drain();

    // Randomized requests against the model
    rand_en = 1;
    for (int i = 0; i < 40; i++) begin
`ifdef AXIS_READ_SCHED_4K_EN
      ra = $urandom & 32'h000F_FFF8;
`else
      ra = $urandom & 32'h000F_FF80;
`endif
      rl = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 300));
      send(ra, rl);
      wait_idle(3000);
    end
    rand_en = 0;
    axi_rlast = 1'b0;
    drain();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
